// File: rtl/fsm_plant_pkg.sv
// Shared types and constants for the fsm_plant climate/irrigation controller.
// State codes are plain localparams so older netlists keep the same encoding.
`timescale 1ns/1ps
package fsm_plant_pkg;

   localparam int TEMP_W  = 3;
   localparam int WATER_W = 4;

   typedef logic [TEMP_W-1:0]  temp_t;
   typedef logic [WATER_W-1:0] water_t;

   typedef logic [1:0] top_state_t;
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_FAULT = 2'b10;

   typedef logic [1:0] climate_state_t;
   localparam logic [1:0] C_OFF     = 2'b00;
   localparam logic [1:0] C_HEAT    = 2'b01;
   localparam logic [1:0] C_COOL_LO = 2'b10;
   localparam logic [1:0] C_COOL_HI = 2'b11;

   typedef logic pump_state_t;
   localparam logic P_OFF = 1'b0;
   localparam logic P_ON  = 1'b1;

   localparam logic [1:0] AC_OFF     = 2'b00;
   localparam logic [1:0] AC_HEAT    = 2'b01;
   localparam logic [1:0] AC_COOL_LO = 2'b10;
   localparam logic [1:0] AC_COOL_HI = 2'b11;

   function automatic logic [1:0] ac_decode(input climate_state_t cs);
      logic [1:0] ac_v;
      case (cs)
         C_HEAT:    ac_v = AC_HEAT;
         C_COOL_LO: ac_v = AC_COOL_LO;
         C_COOL_HI: ac_v = AC_COOL_HI;
         C_OFF:     ac_v = AC_OFF;
         default:   ac_v = AC_OFF;
      endcase
      return ac_v;
   endfunction

endpackage

// File: rtl/fsm_plant_pump_ctrl.sv
// Irrigation pump hysteresis FSM with an optional on-time watchdog
// (FSM_PLANT_PUMP_WDOG_EN) that raises fault back to the top controller.
`timescale 1ns/1ps
module fsm_plant_pump_ctrl
   import fsm_plant_pkg::*;
#(
   parameter int WATER_ON  = 4,
   parameter int WATER_OFF = 12
`ifdef FSM_PLANT_PUMP_WDOG_EN
   ,
   parameter int PUMP_MAX_CYCLES = 16
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hold,
   input  logic [WATER_W-1:0] water,
   output logic               pump,
   output logic               fault
);

   localparam water_t ON_T  = water_t'(WATER_ON);
   localparam water_t OFF_T = water_t'(WATER_OFF);

   pump_state_t state_r;
   pump_state_t state_next_s;
   logic        pump_r;

   // Next pump state; hold forces OFF whenever the top is not running.
   always_comb begin
      state_next_s = P_OFF;
      if (hold) begin
         state_next_s = P_OFF;
      end else begin
         case (state_r)
            P_OFF:   if (water <= ON_T)  state_next_s = P_ON;  else state_next_s = P_OFF;
            P_ON:    if (water >= OFF_T) state_next_s = P_OFF; else state_next_s = P_ON;
            default: state_next_s = P_OFF;
         endcase
      end
   end

   // Pump state register and registered output decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= P_OFF;
         pump_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         pump_r  <= (state_next_s == P_ON);
      end
   end

   assign pump = pump_r;

`ifdef FSM_PLANT_PUMP_WDOG_EN
   localparam int CNT_W = $clog2(PUMP_MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PUMP_MAX_CYCLES);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;

   // Count of consecutive running cycles with the pump driven on, saturating.
   always_comb begin
      cnt_next_s = cnt_r;
      if (hold || (state_next_s != P_ON)) begin
         cnt_next_s = {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
         cnt_next_s = cnt_r;
      end else begin
         cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

   assign fault = (cnt_r == CNT_MAX);
`else
   assign fault = 1'b0;
`endif

endmodule

// File: rtl/fsm_plant.sv
// Smart-farm climate/irrigation controller top: run FSM plus climate FSM.
// Optional pump watchdog and FAULT state enabled by FSM_PLANT_PUMP_WDOG_EN.
`timescale 1ns/1ps
module fsm_plant
   import fsm_plant_pkg::*;
#(
   parameter int TEMP_HEAT_ON     = 1,
   parameter int TEMP_HEAT_OFF    = 3,
   parameter int TEMP_COOL_LO_ON  = 5,
   parameter int TEMP_COOL_HI_ON  = 6,
   parameter int TEMP_COOL_HI_OFF = 4,
   parameter int TEMP_COOL_OFF    = 3,
   parameter int WATER_ON         = 4,
   parameter int WATER_OFF        = 12
`ifdef FSM_PLANT_PUMP_WDOG_EN
   ,
   parameter int PUMP_MAX_CYCLES  = 16
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [TEMP_W-1:0]  temperature,
   input  logic [WATER_W-1:0] water,
   output logic [1:0]         ac,
   output logic               pump
);

   localparam temp_t HEAT_ON_T     = temp_t'(TEMP_HEAT_ON);
   localparam temp_t HEAT_OFF_T    = temp_t'(TEMP_HEAT_OFF);
   localparam temp_t COOL_LO_ON_T  = temp_t'(TEMP_COOL_LO_ON);
   localparam temp_t COOL_HI_ON_T  = temp_t'(TEMP_COOL_HI_ON);
   localparam temp_t COOL_HI_OFF_T = temp_t'(TEMP_COOL_HI_OFF);
   localparam temp_t COOL_OFF_T    = temp_t'(TEMP_COOL_OFF);

   top_state_t     top_r;
   top_state_t     top_next_s;
   climate_state_t climate_r;
   climate_state_t climate_next_s;
   logic [1:0]     ac_r;
   logic           hold_s;
   logic           fault_s;
   logic           pump_s;

   // Run/idle/fault control; start low always returns to IDLE.
   always_comb begin
      top_next_s = ST_IDLE;
      if (!start) begin
         top_next_s = ST_IDLE;
      end else begin
         case (top_r)
            ST_IDLE:  top_next_s = ST_RUN;
            ST_RUN:   if (fault_s) top_next_s = ST_FAULT; else top_next_s = ST_RUN;
`ifdef FSM_PLANT_PUMP_WDOG_EN
            ST_FAULT: top_next_s = ST_FAULT;
`endif
            default:  top_next_s = ST_IDLE;
         endcase
      end
   end

   // Sub-FSMs only evaluate on edges that land in RUN (including IDLE->RUN).
   assign hold_s = (top_next_s != ST_RUN);

   // Climate hysteresis; COOL_HI must step down through COOL_LO.
   always_comb begin
      climate_next_s = climate_r;
      if (hold_s) begin
         climate_next_s = C_OFF;
      end else begin
         case (climate_r)
            C_OFF: begin
               if (temperature <= HEAT_ON_T)          climate_next_s = C_HEAT;
               else if (temperature >= COOL_HI_ON_T)  climate_next_s = C_COOL_HI;
               else if (temperature == COOL_LO_ON_T)  climate_next_s = C_COOL_LO;
               else                                   climate_next_s = C_OFF;
            end
            C_HEAT: begin
               if (temperature >= HEAT_OFF_T) climate_next_s = C_OFF;
               else                           climate_next_s = C_HEAT;
            end
            C_COOL_LO: begin
               if (temperature >= COOL_HI_ON_T)    climate_next_s = C_COOL_HI;
               else if (temperature <= COOL_OFF_T) climate_next_s = C_OFF;
               else                                climate_next_s = C_COOL_LO;
            end
            C_COOL_HI: begin
               if (temperature <= COOL_HI_OFF_T) climate_next_s = C_COOL_LO;
               else                              climate_next_s = C_COOL_HI;
            end
            default: climate_next_s = C_OFF;
         endcase
      end
   end

   // Top and climate state registers with registered ac decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         top_r     <= ST_IDLE;
         climate_r <= C_OFF;
         ac_r      <= AC_OFF;
      end else begin
         top_r     <= top_next_s;
         climate_r <= climate_next_s;
         ac_r      <= ac_decode(climate_next_s);
      end
   end

   fsm_plant_pump_ctrl #(
      .WATER_ON        (WATER_ON),
      .WATER_OFF       (WATER_OFF)
`ifdef FSM_PLANT_PUMP_WDOG_EN
      ,
      .PUMP_MAX_CYCLES (PUMP_MAX_CYCLES)
`endif
   ) u_pump_ctrl (
      .clk   (clk),
      .reset (reset),
      .hold  (hold_s),
      .water (water),
      .pump  (pump_s),
      .fault (fault_s)
   );

   assign ac   = ac_r;
   assign pump = pump_s;

endmodule

// File: tb/tb_fsm_plant.sv
// Directed scoreboard bench for fsm_plant; covers the watchdog path when
// FSM_PLANT_PUMP_WDOG_EN is defined for the build.
`timescale 1ns/1ps
module tb_fsm_plant;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] temperature;
   logic [3:0] water;
   logic [1:0] ac;
   logic       pump;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   fsm_plant dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .temperature (temperature),
      .water       (water),
      .ac          (ac),
      .pump        (pump)
   );

   task automatic check_now(input string tag, input logic [2:0] expv);
      checks++;
      assert ({ac, pump} === expv) else begin
         errors++;
         $error("FAIL %s: observed ac=%b pump=%b, expected ac=%b pump=%b",
                tag, ac, pump, expv[2:1], expv[0]);
      end
   endtask

   // Drive one edge worth of inputs, queue the expectation, compare after the edge.
   task automatic step(input string tag, input logic s, input logic [2:0] t,
                       input logic [3:0] w, input logic [1:0] eac, input logic ep);
      logic [2:0] e;
      @(negedge clk);
      start       = s;
      temperature = t;
      water       = w;
      exp_q.push_back({eac, ep});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_now(tag, e);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b0;
      start       = 1'b1;
      temperature = 3'd0;
      water       = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check_now("reset_hold", 3'b000);

      @(negedge clk);
      reset       = 1'b1;
      temperature = 3'd1;
      water       = 4'd1;
      exp_q.push_back({2'b01, 1'b1});
      @(posedge clk);
      #1;
      check_now("release_first_edge", exp_q.pop_front());

      step("heat_hold_t2",   1'b1, 3'd2, 4'd1, 2'b01, 1'b1);
      step("heat_off_t3",    1'b1, 3'd3, 4'd1, 2'b00, 1'b1);
      step("cool_lo_t5",     1'b1, 3'd5, 4'd1, 2'b10, 1'b1);
      step("cool_hi_t6",     1'b1, 3'd6, 4'd1, 2'b11, 1'b1);
      step("cool_hi_hold_t5",1'b1, 3'd5, 4'd1, 2'b11, 1'b1);
      step("cool_hi_to_lo",  1'b1, 3'd4, 4'd1, 2'b10, 1'b1);
      step("cool_lo_off_t3", 1'b1, 3'd3, 4'd1, 2'b00, 1'b1);

      step("pump_hold_w7",   1'b1, 3'd3, 4'd7,  2'b00, 1'b1);
      step("pump_off_w13",   1'b1, 3'd3, 4'd13, 2'b00, 1'b0);
      step("pump_stay_w7",   1'b1, 3'd3, 4'd7,  2'b00, 1'b0);
      step("pump_on_w4",     1'b1, 3'd3, 4'd4,  2'b00, 1'b1);
      step("pump_hold_w3",   1'b1, 3'd3, 4'd3,  2'b00, 1'b1);
      step("pump_off_w12",   1'b1, 3'd3, 4'd12, 2'b00, 1'b0);
      step("pump_stay_w5",   1'b1, 3'd3, 4'd5,  2'b00, 1'b0);
      step("cool_hi_t7",     1'b1, 3'd7, 4'd5,  2'b11, 1'b0);
      step("cool_hi_keep_t5",1'b1, 3'd5, 4'd5,  2'b11, 1'b0);

      step("stop_edge",      1'b0, 3'd1, 4'd3, 2'b00, 1'b0);
      step("stop_hold1",     1'b0, 3'd1, 4'd3, 2'b00, 1'b0);
      step("stop_hold2",     1'b0, 3'd1, 4'd3, 2'b00, 1'b0);
      step("restart_edge",   1'b1, 3'd1, 4'd3, 2'b01, 1'b1);

      step("heat_off_t6",    1'b1, 3'd6, 4'd3, 2'b00, 1'b1);
      step("cool_hi_run",    1'b1, 3'd6, 4'd3, 2'b11, 1'b1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_now("async_reset_midrun", 3'b000);
      @(posedge clk);
      #1;
      check_now("reset_held_edge", 3'b000);
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;

`ifdef FSM_PLANT_PUMP_WDOG_EN
      for (int i = 0; i < 16; i++) begin
         step("wdog_pump_on", 1'b1, 3'd3, 4'd2, 2'b00, 1'b1);
      end
      step("wdog_fault_entry", 1'b1, 3'd3, 4'd2, 2'b00, 1'b0);
      step("wdog_fault_hold",  1'b1, 3'd3, 4'd2, 2'b00, 1'b0);
      step("wdog_fault_clear", 1'b0, 3'd3, 4'd2, 2'b00, 1'b0);
      step("wdog_restart",     1'b1, 3'd3, 4'd2, 2'b00, 1'b1);
`else
      for (int i = 0; i < 20; i++) begin
         step("no_wdog_pump_on", 1'b1, 3'd3, 4'd2, 2'b00, 1'b1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
